lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencer between the EX/MEM pipeline stage and the data-memory bus. It takes the decoded memory controls (`dmem_req`, `dmem_wr_en`, `dmem_size`, `dmem_zero_extend`) plus address and store data. It runs a valid/ready request and response transaction on the bus, forms byte enables and lane-replicated store data, and aligns and extends load data. It holds the pipeline with `lsu_stall` until the access completes.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dmem_req`  in  1  memory instruction present; held stable while `lsu_stall`=1.
- `dmem_wr_en`  in  1  1 = store, 0 = load.
- `dmem_size`  in  mem_size_t  BYTE / HALF_WORD / WORD.
- `dmem_zero_extend`  in  1  load zero-extend (LBU/LHU).
- `dmem_addr`  in  ADDR_W  byte address (ALU result).
- `dmem_wdata`  in  32  store data (rs2), low bytes significant.
- `lsu_stall`  out  1  freeze PC and upstream pipeline registers.
- `ld_valid`  out  1  one-cycle completion pulse.
- `ld_data`  out  32  aligned, extended load result; valid with `ld_valid`.
- `misalign_err`  out  1  one-cycle pulse; meaningful only with `LSU_MISALIGN_TRAP_EN`.
- `mem_req_valid`  out  1  bus request valid.
- `mem_req_ready`  in  1  bus accepts the request when valid && ready.
- `mem_addr`  out  ADDR_W  word-aligned address (`[1:0]`=0).
- `mem_we`  out  1  write request.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rsp_valid`  in  1  load response valid, at least 1 cycle after acceptance.
- `mem_rdata`  in  32  load response word.

## Operation
- States: IDLE, REQ, RSP, DONE. On reset the state is IDLE and all registered outputs are 0: `mem_req_valid`, `mem_addr`, `mem_we`, `mem_be`, `mem_wdata`, `ld_valid`, `ld_data`, `misalign_err`.
- IDLE, with `dmem_req`=1:
  - Capture `addr[1:0]`, size, zero-extend and we.
  - Drive registered bus fields and go to REQ.
  - If trapping on misalign: go to DONE instead, with no bus request.
- REQ: `mem_req_valid`=1 and bus fields stable until the handshake.
  - On handshake: a store goes to DONE; a load goes to RSP.
- RSP: wait for `mem_rsp_valid`. When it arrives, register `ld_data` and go to DONE.
- DONE:
  - `ld_valid`=1 (also for stores) for exactly one cycle, then IDLE.
  - The pipeline advances on this edge; the IDLE cycle after DONE accepts the next request.
- `lsu_stall` = (IDLE && `dmem_req`) || REQ || RSP. It is combinational and is 0 in DONE.
- Byte enables:
  - BYTE: `1<<addr[1:0]`.
  - HALF_WORD: `addr[1] ? 4'b1100 : 4'b0011`.
  - WORD: `4'b1111`.
- Store data: BYTE `{4{wdata[7:0]}}`; HALF_WORD `{2{wdata[15:0]}}`; WORD `wdata`.
- Load data:
  - Shift `mem_rdata` right by 8×`addr[1:0]` (HALF_WORD uses `addr[1]` only).
  - Take 8/16/32 bits, then sign-extend, or zero-extend when `dmem_zero_extend`.
- Misaligned access is defined as HALF_WORD with `addr[0]`=1, or WORD with `addr[1:0]`≠0.
- `mem_rsp_valid` outside RSP is ignored.
- `dmem_req` changing while stalled is a pipeline protocol violation; captured values are used.
- Reset mid-transaction returns to IDLE immediately. The outstanding bus transaction is abandoned and the memory side must discard it.

## Timing
- Store with `mem_req_ready`=1: request sampled at cycle 0, REQ at cycle 1, DONE at cycle 2. Stall is high for cycles 0–1.
- Load with ready=1 and response 1 cycle after acceptance: REQ at cycle 1, RSP at cycle 2, DONE at cycle 3. Stall is high for cycles 0–2.
- Every ready or response wait cycle adds one stall cycle.
- Trapped misalign: IDLE to DONE in one cycle; stall high for 1 cycle.
- Back-to-back accesses: the minimum spacing is DONE, then IDLE, then the next REQ.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access skips the bus entirely.
  - DONE pulses `ld_valid` and `misalign_err`, with `ld_data`=0.
  - No register-file write suppression is done here; the trap handler owns that.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `misalign_err` is tied to 0.
  - Misaligned accesses issue with the byte-enable and extract rules above, i.e. `addr[0]`, or `addr[1:0]` for WORD, is ignored.

## Test plan
- SW, addr 0x100, wdata 0xDEADBEEF, ready=1 → `mem_addr`=0x100, `mem_be`=1111, `mem_we`=1; stall for 2 cycles; `ld_valid` at cycle 2.
- SB, addr 0x203, wdata 0x000000A5 → `mem_addr`=0x200, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5.
- LB, addr 0x302, rdata 0x12F45678, response 3 cycles after acceptance → `ld_data`=0xFFFFFFF4. The same access as LBU → 0x000000F4. Stall lasts 5 cycles.
- LH, addr 0x402, rdata 0x8001FFFF → `ld_data`=0xFFFF8001. The same access as LHU → 0x00008001.
- LW, addr 0x501:
  - With the macro: no `mem_req_valid`, `misalign_err` pulse, `ld_data`=0.
  - Without the macro: `mem_addr`=0x500, `be`=1111.
- Load in RSP with `reset` asserted → state IDLE and all outputs 0 asynchronously. A later `mem_rsp_valid` is ignored, and the next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store sequencer.
//   mem_size_t : access width of a load/store (BYTE, HALF_WORD, WORD).
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } mem_size_t;

endpackage

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the EX/MEM stage and the data-memory
// bus. Runs one valid/ready request (plus a response for loads) per memory
// instruction, forms byte enables and lane-replicated store data, aligns and
// extends load data, and stalls the pipeline until the access completes.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned HALF_WORD/WORD accesses skip the bus and pulse
//               misalign_err together with ld_valid (ld_data = 0).
//   undefined : misalign_err is tied to 0 and the low address bits that do
//               not fit the access size are ignored.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   dmem_req/wr_en/size/zero_extend/addr/wdata   decoded memory controls
//   lsu_stall                   combinational pipeline hold
//   ld_valid, ld_data           one-cycle completion pulse and load result
//   misalign_err                one-cycle trap pulse (trap build only)
//   mem_req_valid/ready, mem_addr, mem_we, mem_be, mem_wdata   bus request
//   mem_rsp_valid, mem_rdata    bus load response
//
// state | meaning
// IDLE  | waiting for dmem_req; captures access attributes
// REQ   | mem_req_valid high, bus fields held until handshake
// RSP   | load accepted, waiting for mem_rsp_valid
// DONE  | ld_valid pulse; pipeline advances on this edge
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dmem_req,
    input  logic              dmem_wr_en,
    input  mem_size_t         dmem_size,
    input  logic              dmem_zero_extend,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [31:0]       dmem_wdata,
    output logic              lsu_stall,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic              misalign_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [1:0]        r_off;
    mem_size_t         r_size;
    logic              r_zx;
    logic              r_we;

    logic              r_mem_req_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic              r_ld_valid;
    logic [31:0]       r_ld_data;

    logic              w_accept;
    logic              w_trap;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [1:0]        w_rd_off;
    logic [31:0]       w_rd_shift;
    logic [31:0]       w_ld_ext;

    assign w_accept = (r_state == IDLE) && dmem_req;

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misalign_err;

    always_comb begin
        w_misalign = 1'b0;
        if (dmem_size == HALF_WORD)
            w_misalign = dmem_addr[0];
        else if (dmem_size == WORD)
            w_misalign = (dmem_addr[1:0] != 2'b00);
    end

    assign w_trap = w_misalign;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_misalign_err <= 1'b0;
        else
            r_misalign_err <= w_accept && w_trap;
    end

    assign misalign_err = r_misalign_err;
`else
    assign w_trap       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Byte enables and replicated store data from the live request.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = dmem_wdata;
        case (dmem_size)
            BYTE: begin
                w_be    = 4'b0001 << dmem_addr[1:0];
                w_wdata = {4{dmem_wdata[7:0]}};
            end
            HALF_WORD: begin
                w_be    = dmem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{dmem_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = dmem_wdata;
            end
        endcase
    end

    // Load alignment uses the captured offset; halfwords drop addr[0] and
    // words drop both bits so misaligned accesses behave like aligned ones.
    always_comb begin
        w_rd_off = 2'b00;
        case (r_size)
            BYTE:      w_rd_off = r_off;
            HALF_WORD: w_rd_off = {r_off[1], 1'b0};
            default:   w_rd_off = 2'b00;
        endcase
        w_rd_shift = mem_rdata >> {w_rd_off, 3'b000};
        case (r_size)
            BYTE:      w_ld_ext = r_zx ? {24'b0, w_rd_shift[7:0]}
                                       : {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            HALF_WORD: w_ld_ext = r_zx ? {16'b0, w_rd_shift[15:0]}
                                       : {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            default:   w_ld_ext = w_rd_shift;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        lsu_stall   = 1'b0;
        case (r_state)
            IDLE: begin
                lsu_stall = dmem_req;
                if (dmem_req)
                    w_state_nxt = w_trap ? DONE : REQ;
            end
            REQ: begin
                lsu_stall = 1'b1;
                if (mem_req_ready)
                    w_state_nxt = r_we ? DONE : RSP;
            end
            RSP: begin
                lsu_stall = 1'b1;
                if (mem_rsp_valid)
                    w_state_nxt = DONE;
            end
            default: begin
                lsu_stall   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_off           <= 2'b00;
            r_size          <= BYTE;
            r_zx            <= 1'b0;
            r_we            <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_we        <= 1'b0;
            r_mem_be        <= 4'b0000;
            r_mem_wdata     <= 32'h0;
            r_ld_valid      <= 1'b0;
            r_ld_data       <= 32'h0;
        end else begin
            r_ld_valid <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_off  <= dmem_addr[1:0];
                r_size <= dmem_size;
                r_zx   <= dmem_zero_extend;
                r_we   <= dmem_wr_en;
                if (w_trap) begin
                    r_ld_data <= 32'h0;
                end else begin
                    r_mem_req_valid <= 1'b1;
                    r_mem_addr      <= {dmem_addr[ADDR_W-1:2], 2'b00};
                    r_mem_we        <= dmem_wr_en;
                    r_mem_be        <= w_be;
                    r_mem_wdata     <= w_wdata;
                end
            end
            if ((r_state == REQ) && mem_req_ready)
                r_mem_req_valid <= 1'b0;
            if ((r_state == RSP) && mem_rsp_valid)
                r_ld_data <= w_ld_ext;
        end
    end

    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_we        = r_mem_we;
    assign mem_be        = r_mem_be;
    assign mem_wdata     = r_mem_wdata;
    assign ld_valid      = r_ld_valid;
    assign ld_data       = r_ld_data;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vectors for lsu_ctrl with hand-computed expectations.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk;
    logic        reset;
    logic        dmem_req;
    logic        dmem_wr_en;
    mem_size_t   dmem_size;
    logic        dmem_zero_extend;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        lsu_stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        misalign_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    // Values captured by run() for the caller to check.
    logic [31:0] cap_addr, cap_wdata, cap_ld;
    logic [3:0]  cap_be;
    logic        cap_we, cap_mis, cap_lv_after;
    int          cap_stall, cap_done, cap_req_cycles;

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .dmem_req        (dmem_req),
        .dmem_wr_en      (dmem_wr_en),
        .dmem_size       (dmem_size),
        .dmem_zero_extend(dmem_zero_extend),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .lsu_stall       (lsu_stall),
        .ld_valid        (ld_valid),
        .ld_data         (ld_data),
        .misalign_err    (misalign_err),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rdata       (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // One access. Cycle 0 is the cycle dmem_req is first presented.
    // rdy_wait: REQ cycles with ready low; rsp_delay: cycles from acceptance
    // to mem_rsp_valid.
    task automatic run(input logic we, input mem_size_t sz, input logic zx,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int rdy_wait, input int rsp_delay,
                       input logic [31:0] rdata);
        int cyc, acc, req_cyc;
        bit done;
        cap_addr = 'x; cap_wdata = 'x; cap_be = 'x; cap_we = 1'bx;
        cap_ld = 'x; cap_mis = 1'bx; cap_lv_after = 1'bx;
        cap_stall = 0; cap_done = -1; cap_req_cycles = 0;
        @(negedge clk);
        dmem_req = 1'b1; dmem_wr_en = we; dmem_size = sz;
        dmem_zero_extend = zx; dmem_addr = addr; dmem_wdata = wdata;
        cyc = 0; acc = -1; req_cyc = 0; done = 0;
        while (!done && cyc < 60) begin
            #1;
            if (lsu_stall) cap_stall++;
            mem_rsp_valid = 1'b0;
            mem_rdata     = 32'hBAD0BAD0;
            if (mem_req_valid) begin
                cap_req_cycles++;
                cap_addr = mem_addr; cap_be = mem_be;
                cap_we = mem_we; cap_wdata = mem_wdata;
                mem_req_ready = (req_cyc >= rdy_wait);
                if (mem_req_ready) acc = cyc;
                req_cyc++;
            end else begin
                mem_req_ready = 1'b0;
            end
            if (acc >= 0 && cyc == acc + rsp_delay) begin
                mem_rsp_valid = 1'b1;
                mem_rdata     = rdata;
            end
            if (ld_valid) begin
                done = 1; cap_done = cyc;
                cap_ld = ld_data; cap_mis = misalign_err;
                dmem_req = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        #1;
        cap_lv_after = ld_valid;
    endtask

    initial begin
        reset = 1'b1;
        dmem_req = 1'b0; dmem_wr_en = 1'b0; dmem_size = BYTE;
        dmem_zero_extend = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_be", {28'b0, mem_be}, 32'h0);
        chk("rst_ld_valid", {31'b0, ld_valid}, 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_stall", {31'b0, lsu_stall}, 32'h0);
        reset = 1'b0;

        // SW 0x100
        run(1'b1, WORD, 1'b0, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0);
        chk("sw_addr", cap_addr, 32'h100);
        chk("sw_be", {28'b0, cap_be}, 32'hF);
        chk("sw_we", {31'b0, cap_we}, 32'h1);
        chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
        chk("sw_stall", cap_stall, 2);
        chk("sw_done_cyc", cap_done, 2);
        chk("sw_lv_one_cycle", {31'b0, cap_lv_after}, 32'h0);
        chk("sw_mis", {31'b0, cap_mis}, 32'h0);

        // SB 0x203, two ready-wait cycles
        run(1'b1, BYTE, 1'b0, 32'h203, 32'h000000A5, 2, 1, 32'h0);
        chk("sb_addr", cap_addr, 32'h200);
        chk("sb_be", {28'b0, cap_be}, 32'h8);
        chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
        chk("sb_stall_wait", cap_stall, 4);

        // SH 0x002
        run(1'b1, HALF_WORD, 1'b0, 32'h002, 32'h1234ABCD, 0, 1, 32'h0);
        chk("sh_be", {28'b0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCDABCD);

        // LB / LBU 0x302, response 3 cycles after acceptance
        run(1'b0, BYTE, 1'b0, 32'h302, 32'h0, 0, 3, 32'h12F45678);
        chk("lb_data", cap_ld, 32'hFFFFFFF4);
        chk("lb_stall", cap_stall, 5);
        chk("lb_be", {28'b0, cap_be}, 32'h4);
        chk("lb_we", {31'b0, cap_we}, 32'h0);
        run(1'b0, BYTE, 1'b1, 32'h302, 32'h0, 0, 3, 32'h12F45678);
        chk("lbu_data", cap_ld, 32'h000000F4);

        // LH / LHU 0x402
        run(1'b0, HALF_WORD, 1'b0, 32'h402, 32'h0, 0, 1, 32'h8001FFFF);
        chk("lh_data", cap_ld, 32'hFFFF8001);
        chk("lh_stall", cap_stall, 3);
        chk("lh_done_cyc", cap_done, 3);
        run(1'b0, HALF_WORD, 1'b1, 32'h402, 32'h0, 0, 1, 32'h8001FFFF);
        chk("lhu_data", cap_ld, 32'h00008001);
        chk("lhu_be", {28'b0, cap_be}, 32'hC);

        // LW 0x501 (misaligned)
        run(1'b0, WORD, 1'b0, 32'h501, 32'h0, 0, 1, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_mis_no_req", cap_req_cycles, 0);
        chk("lw_mis_err", {31'b0, cap_mis}, 32'h1);
        chk("lw_mis_ld", cap_ld, 32'h0);
        chk("lw_mis_stall", cap_stall, 1);
        chk("lw_mis_done_cyc", cap_done, 1);
`else
        chk("lw_mis_addr", cap_addr, 32'h500);
        chk("lw_mis_be", {28'b0, cap_be}, 32'hF);
        chk("lw_mis_ld", cap_ld, 32'h11223344);
        chk("lw_mis_err", {31'b0, cap_mis}, 32'h0);
`endif

        // LW 0x600, reset while waiting in RSP
        @(negedge clk);
        dmem_req = 1'b1; dmem_wr_en = 1'b0; dmem_size = WORD;
        dmem_zero_extend = 1'b0; dmem_addr = 32'h600; dmem_wdata = 32'h55;
        @(negedge clk); #1;
        mem_req_ready = 1'b1;
        @(negedge clk); #1;
        mem_req_ready = 1'b0;
        chk("rsp_stall", {31'b0, lsu_stall}, 32'h1);
        chk("rsp_addr", mem_addr, 32'h600);
        dmem_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("arst_stall", {31'b0, lsu_stall}, 32'h0);
        chk("arst_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_wdata", mem_wdata, 32'h0);
        chk("arst_be", {28'b0, mem_be}, 32'h0);
        chk("arst_we", {31'b0, mem_we}, 32'h0);
        chk("arst_ld_valid", {31'b0, ld_valid}, 32'h0);
        chk("arst_ld_data", ld_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h77777777;
        @(negedge clk); #1;
        mem_rsp_valid = 1'b0;
        chk("stale_rsp_lv", {31'b0, ld_valid}, 32'h0);
        chk("stale_rsp_data", ld_data, 32'h0);

        run(1'b0, WORD, 1'b0, 32'h700, 32'h0, 0, 1, 32'hCAFEF00D);
        chk("post_rst_lw_data", cap_ld, 32'hCAFEF00D);
        chk("post_rst_lw_addr", cap_addr, 32'h700);
        chk("post_rst_lw_done", cap_done, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
